// File: rtl/datapath_p2_pkg.sv
// Shared constants for the phase-2 datapath: opcodes, CON condition codes,
// bus-source ordering and the C-field sign-extension helper.
package datapath_p2_pkg;
  localparam int W    = 32;
  localparam int NREG = 16;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;

  typedef enum logic [1:0] {
    C2_ZERO = 2'b00,
    C2_NZ   = 2'b01,
    C2_POS  = 2'b10,
    C2_NEG  = 2'b11
  } c2_e;

  // Declaration order after SRC_NONE is the bus priority, highest first.
  typedef enum logic [3:0] {
    SRC_NONE, SRC_GPR, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO,
    SRC_PC, SRC_MDR, SRC_INPORT, SRC_C
  } bus_src_e;

  function automatic logic [W-1:0] sext19(input logic [18:0] c);
    return {{(W-19){c[18]}}, c};
  endfunction
endpackage

// File: rtl/datapath_p2_if.sv
// Control strobes and external data ports between the control unit and the datapath.
interface datapath_p2_if;
  logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic        IncPC, Read, Write;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic [31:0] Mdatain, InPort;
  logic [31:0] outp;

  modport master (
    output PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
    output IncPC, Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe,
    output Mdatain, InPort,
    input  outp
  );

  modport slave (
    input  PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
    input  IncPC, Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe,
    input  Mdatain, InPort,
    output outp
  );
endinterface

// File: rtl/datapath_p2_alu32.sv
// Combinational ALU: A = Y, B = bus; 64-bit result, upper half used only by mul/div.
module alu32
  import datapath_p2_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_op,
  input  logic        i_incpc,
  output logic [63:0] o_res
);
  logic [4:0]         w_sh;
  logic [63:0]        w_prod, w_ror2, w_rol2;
  logic signed [31:0] w_sq, w_sr, w_sra;
  logic [31:0]        w_quo, w_rem;

  assign w_sh   = i_b[4:0];
  assign w_prod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  // Kept as separate signed nets so the zero-guard mux cannot turn them unsigned.
  assign w_sq   = $signed(i_a) / $signed(i_b);
  assign w_sr   = $signed(i_a) % $signed(i_b);
  assign w_quo  = (i_b == '0) ? '0  : w_sq;
  assign w_rem  = (i_b == '0) ? i_a : w_sr;
  assign w_sra  = $signed(i_a) >>> w_sh;
  assign w_ror2 = {i_a, i_a} >> w_sh;
  assign w_rol2 = {i_a, i_a} << w_sh;

  always_comb begin
    o_res = '0;
    if (i_incpc) begin
      o_res[31:0] = i_b + 32'd1;
    end else begin
      case (i_op)
        OP_SUB:          o_res[31:0] = i_a - i_b;
        OP_AND, OP_ANDI: o_res[31:0] = i_a & i_b;
        OP_OR,  OP_ORI:  o_res[31:0] = i_a | i_b;
        OP_SHR:          o_res[31:0] = i_a >> w_sh;
        OP_SHRA:         o_res[31:0] = w_sra;
        OP_SHL:          o_res[31:0] = i_a << w_sh;
        OP_ROR:          o_res[31:0] = w_ror2[31:0];
        OP_ROL:          o_res[31:0] = w_rol2[63:32];
        OP_MUL:          o_res       = w_prod;
        OP_DIV:          o_res       = {w_rem, w_quo};
        OP_NEG:          o_res[31:0] = -i_b;
        OP_NOT:          o_res[31:0] = ~i_b;
        default:         o_res[31:0] = i_a + i_b;
      endcase
    end
  end
endmodule

// File: rtl/datapath_p2.sv
// Phase-2 bus datapath: register file, special registers, ALU, select/encode,
// CON flip-flop and I/O ports sharing one combinational 32-bit bus.
module datapath_p2
  import datapath_p2_pkg::*;
(
  input  logic          Clock,
  input  logic          Clear,
  datapath_p2_if.slave  ctl
);
  logic [NREG-1:0][W-1:0] r_gpr;
  logic [W-1:0]  r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_inport, r_outp;
  logic [63:0]   r_z;
  logic          r_con;

  logic [3:0]      w_sel;
  logic [NREG-1:0] w_onehot, w_ld_en, w_drv_en;
  logic [W-1:0]    w_bus, w_cval;
  logic [63:0]     w_alu;
  logic            w_con_eval;
  bus_src_e        w_src;
  logic [3:0]      w_gpr_idx;

  assign w_sel    = ({4{ctl.Gra}} & r_ir[26:23]) |
                    ({4{ctl.Grb}} & r_ir[22:19]) |
                    ({4{ctl.Grc}} & r_ir[18:15]);
  assign w_onehot = 16'b1 << w_sel;
  assign w_ld_en  = {NREG{ctl.Rin}} & w_onehot;
  assign w_drv_en = {NREG{ctl.Rout | ctl.BAout}} & w_onehot;
  assign w_cval   = sext19(r_ir[18:0]);

  always_comb begin
    w_src     = SRC_NONE;
    w_gpr_idx = '0;
    // Walk downward so the lowest-numbered driven register wins.
    for (int i = NREG-1; i >= 0; i--) begin
      if (w_drv_en[i]) begin
        w_src     = SRC_GPR;
        w_gpr_idx = i[3:0];
      end
    end
    if (w_src == SRC_NONE) begin
      if      (ctl.HIout)     w_src = SRC_HI;
      else if (ctl.LOout)     w_src = SRC_LO;
      else if (ctl.Zhiout)    w_src = SRC_ZHI;
      else if (ctl.Zlowout)   w_src = SRC_ZLO;
      else if (ctl.PCout)     w_src = SRC_PC;
      else if (ctl.MDRout)    w_src = SRC_MDR;
      else if (ctl.InPortout) w_src = SRC_INPORT;
      else if (ctl.Cout)      w_src = SRC_C;
    end
  end

  always_comb begin
    w_bus = '0;
    case (w_src)
      // Base-address use of R0 reads as zero; a plain Rout still sees R0.
      SRC_GPR:    w_bus = (w_gpr_idx == 4'd0 && !ctl.Rout) ? '0 : r_gpr[w_gpr_idx];
      SRC_HI:     w_bus = r_hi;
      SRC_LO:     w_bus = r_lo;
      SRC_ZHI:    w_bus = r_z[63:32];
      SRC_ZLO:    w_bus = r_z[31:0];
      SRC_PC:     w_bus = r_pc;
      SRC_MDR:    w_bus = r_mdr;
      SRC_INPORT: w_bus = r_inport;
      SRC_C:      w_bus = w_cval;
      default:    w_bus = '0;
    endcase
  end

  always_comb begin
    w_con_eval = 1'b0;
    case (c2_e'(r_ir[20:19]))
      C2_ZERO: w_con_eval = (w_bus == '0);
      C2_NZ:   w_con_eval = (w_bus != '0);
      C2_POS:  w_con_eval = ~w_bus[31];
      C2_NEG:  w_con_eval = w_bus[31];
      default: w_con_eval = 1'b0;
    endcase
  end

  alu32 u_alu (
    .i_a     (r_y),
    .i_b     (w_bus),
    .i_op    (r_ir[31:27]),
    .i_incpc (ctl.IncPC),
    .o_res   (w_alu)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_gpr <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (w_ld_en[i]) r_gpr[i] <= w_bus;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_y      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_z      <= '0;
      r_con    <= 1'b0;
      r_inport <= '0;
      r_outp   <= '0;
    end else begin
      if (ctl.PCin)      r_pc     <= w_bus;
      if (ctl.IRin)      r_ir     <= w_bus;
      if (ctl.MARin)     r_mar    <= w_bus;
      if (ctl.MDRin)     r_mdr    <= ctl.Read ? ctl.Mdatain : w_bus;
      if (ctl.Yin)       r_y      <= w_bus;
      if (ctl.HIin)      r_hi     <= w_bus;
      if (ctl.LOin)      r_lo     <= w_bus;
      if (ctl.Zin)       r_z      <= w_alu;
      if (ctl.CONIn)     r_con    <= w_con_eval;
      if (ctl.Strobe)    r_inport <= ctl.InPort;
      if (ctl.OutPortin) r_outp   <= w_bus;
    end
  end

  assign ctl.outp = r_outp;
endmodule

// File: tb/tb_datapath_p2.sv
// Directed bench for datapath_p2: fetch, jr, add, mul/div, CON/BAout, ports and Clear.
module tb_datapath_p2;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  datapath_p2_if ctl();

  datapath_p2 dut (
    .Clock (clk),
    .Clear (clr),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ctl.PCout = 0; ctl.Zhiout = 0; ctl.Zlowout = 0; ctl.MDRout = 0;
    ctl.HIout = 0; ctl.LOout = 0; ctl.InPortout = 0;
    ctl.MARin = 0; ctl.Zin = 0; ctl.PCin = 0; ctl.MDRin = 0; ctl.IRin = 0;
    ctl.Yin = 0; ctl.HIin = 0; ctl.LOin = 0; ctl.OutPortin = 0;
    ctl.IncPC = 0; ctl.Read = 0; ctl.Write = 0;
    ctl.Gra = 0; ctl.Grb = 0; ctl.Grc = 0; ctl.Rin = 0; ctl.Rout = 0;
    ctl.BAout = 0; ctl.Cout = 0; ctl.CONIn = 0; ctl.Strobe = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic inp(input logic [31:0] v);
    ctl.InPort = v; ctl.Strobe = 1; tick();
  endtask

  task automatic load_ir(input logic [31:0] v);
    ctl.Mdatain = v; ctl.Read = 1; ctl.MDRin = 1; tick();
    ctl.MDRout = 1; ctl.IRin = 1; tick();
  endtask

  // fld: 0 = Ra, 1 = Rb, 2 = Rc
  task automatic set_reg(input int fld, input logic [31:0] v);
    inp(v);
    ctl.InPortout = 1; ctl.Rin = 1;
    ctl.Gra = (fld == 0); ctl.Grb = (fld == 1); ctl.Grc = (fld == 2);
    tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    inp(v);
    ctl.InPortout = 1; ctl.Yin = 1; tick();
  endtask

  task automatic z_from_inport(input logic [31:0] v);
    inp(v);
    ctl.InPortout = 1; ctl.Zin = 1; tick();
  endtask

  initial begin
    idle();
    ctl.Mdatain = '0; ctl.InPort = '0;
    #12;
    chk("rst_outp", {32'h0, ctl.outp}, 64'h0);
    chk("rst_pc",   {32'h0, dut.r_pc}, 64'h0);
    chk("rst_z",    dut.r_z, 64'h0);
    clr = 1'b0;
    @(negedge clk);

    // fetch
    ctl.PCout = 1; ctl.MARin = 1; ctl.IncPC = 1; ctl.Zin = 1; tick();
    chk("fetch_mar", {32'h0, dut.r_mar}, 64'h0);
    chk("fetch_z",   dut.r_z, 64'h1);
    ctl.Zlowout = 1; ctl.PCin = 1; ctl.Read = 1; ctl.MDRin = 1;
    ctl.Mdatain = 32'hA080_0000; tick();
    chk("fetch_pc",  {32'h0, dut.r_pc},  64'h1);
    chk("fetch_mdr", {32'h0, dut.r_mdr}, 64'hA080_0000);
    ctl.MDRout = 1; ctl.IRin = 1; tick();
    chk("fetch_ir",  {32'h0, dut.r_ir},  64'hA080_0000);

    // jr R1
    set_reg(0, 32'h25);
    ctl.Gra = 1; ctl.Rout = 1; ctl.PCin = 1; tick();
    chk("jr_pc", {32'h0, dut.r_pc}, 64'h25);

    // no source asserted -> bus 0
    ctl.Yin = 1; tick();
    chk("bus_idle", {32'h0, dut.r_y}, 64'h0);

    // add R3,R1,R2
    load_ir(32'h1989_0000);
    set_reg(1, 32'h7);
    set_reg(2, 32'hFFFF_FFFE);
    ctl.Grb = 1; ctl.Rout = 1; ctl.Yin = 1; tick();
    ctl.Grc = 1; ctl.Rout = 1; ctl.Zin = 1; tick();
    chk("add_z", dut.r_z, 64'h5);
    ctl.Zlowout = 1; ctl.Gra = 1; ctl.Rin = 1; tick();
    chk("add_r3", {32'h0, dut.r_gpr[3]}, 64'h5);

    // bus priority: PC beats In.Port
    inp(32'hDEAD_BEEF);
    ctl.PCout = 1; ctl.InPortout = 1; ctl.Yin = 1; tick();
    chk("prio_pc", {32'h0, dut.r_y}, 64'h25);

    // mul
    load_ir(32'h7800_0000);
    set_y(32'hFFFF_FFFA);
    z_from_inport(32'h4);
    chk("mul_z", dut.r_z, 64'hFFFF_FFFF_FFFF_FFE8);

    // div
    load_ir(32'h8000_0000);
    set_y(32'hFFFF_FFFA);
    z_from_inport(32'h4);
    chk("div_z", dut.r_z, 64'hFFFF_FFFE_FFFF_FFFF);
    ctl.Zhiout = 1; ctl.HIin = 1; tick();
    chk("div_hi", {32'h0, dut.r_hi}, 64'hFFFF_FFFE);
    z_from_inport(32'h0);
    chk("div0_z", dut.r_z, 64'hFFFF_FFFA_0000_0000);

    // ror 0x80000001 by 4
    load_ir(32'h5000_0000);
    set_y(32'h8000_0001);
    z_from_inport(32'h4);
    chk("ror_z", dut.r_z, 64'h1800_0000);

    // Cout sign-extends IR[18:0]
    load_ir(32'h0007_FFFF);
    ctl.Cout = 1; ctl.Yin = 1; tick();
    chk("cout_y", {32'h0, dut.r_y}, 64'hFFFF_FFFF);

    // CON and BAout, Ra = R0, C2 = 00
    load_ir(32'h9800_0000);
    set_reg(0, 32'h55);
    ctl.Gra = 1; ctl.BAout = 1; ctl.CONIn = 1; ctl.Yin = 1; tick();
    chk("ba_con", {63'h0, dut.r_con}, 64'h1);
    chk("ba_y",   {32'h0, dut.r_y},   64'h0);
    ctl.Gra = 1; ctl.Rout = 1; ctl.Yin = 1; tick();
    chk("rout_r0", {32'h0, dut.r_y}, 64'h55);
    load_ir(32'h9808_0000);
    ctl.CONIn = 1; tick();
    chk("con_nz", {63'h0, dut.r_con}, 64'h0);
    load_ir(32'h9818_0000);
    inp(32'h8000_0000);
    ctl.InPortout = 1; ctl.CONIn = 1; tick();
    chk("con_neg", {63'h0, dut.r_con}, 64'h1);

    // ports
    inp(32'h1234);
    ctl.InPortout = 1; ctl.OutPortin = 1; tick();
    chk("outp", {32'h0, ctl.outp}, 64'h1234);

    // Clear mid-cycle
    #3 clr = 1'b1;
    #1;
    chk("clr_outp", {32'h0, ctl.outp}, 64'h0);
    chk("clr_pc",   {32'h0, dut.r_pc}, 64'h0);
    ctl.Mdatain = 32'hCAFE_F00D; ctl.Read = 1; ctl.MDRin = 1; tick();
    chk("clr_mdr", {32'h0, dut.r_mdr}, 64'h0);
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
